// File: rtl/mcb_arb2.sv
// mcb_arb2: two-port round-robin burst arbiter in front of the MCB command/data interface.
// Owner FIFOs remember which port issued each burst so data beats are steered back to it.

module mcb_arb2_own #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       port,
    input  logic       bl8,
    input  logic       beat,
    output logic       full,
    output logic       err,
    output logic [1:0] own
);
    localparam int AW = $clog2(DEPTH);
    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic [2:0]    beats;
    logic          empty, pop;
    always_comb begin
        empty = cnt == '0;
        full  = cnt == (AW+1)'(DEPTH);
        own   = empty ? 2'b00 : (mem[rp][1] ? 2'b10 : 2'b01);
        err   = beat & empty;
        pop   = beat & ~empty & (beats == (mem[rp][0] ? 3'd7 : 3'd3));
    end
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= {port, bl8};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            cnt   <= '0;
            beats <= '0;
        end else begin
            wp    <= wp + AW'(push);
            rp    <= rp + AW'(pop);
            cnt   <= cnt + (AW+1)'(push) - (AW+1)'(pop);
            beats <= pop ? 3'd0 : beats + 3'(beat & ~empty);
        end
    end
endmodule

module mcb_arb2 #(
    parameter int MCB_B_W   = 2,
    parameter int MCB_R_W   = 13,
    parameter int MCB_C_W   = 9,
    parameter int MCB_D_W   = 32,
    parameter int MCB_BE_W  = 4,
    parameter int TAG_DEPTH = 4
) (
    input  logic                mcb_clk,
    input  logic                mcb_rst,
    input  logic                p0_req,
    input  logic                p0_wr_n,
    input  logic [1:0]          p0_bl,
    input  logic [MCB_B_W-1:0]  p0_ba,
    input  logic [MCB_R_W-1:0]  p0_ra,
    input  logic [MCB_C_W-1:0]  p0_ca,
    output logic                p0_ack,
    input  logic [MCB_D_W-1:0]  p0_wdat,
    input  logic [MCB_BE_W-1:0] p0_wbe,
    output logic                p0_wdat_req,
    output logic                p0_rdat_vld,
    input  logic                p1_req,
    input  logic                p1_wr_n,
    input  logic [1:0]          p1_bl,
    input  logic [MCB_B_W-1:0]  p1_ba,
    input  logic [MCB_R_W-1:0]  p1_ra,
    input  logic [MCB_C_W-1:0]  p1_ca,
    output logic                p1_ack,
    input  logic [MCB_D_W-1:0]  p1_wdat,
    input  logic [MCB_BE_W-1:0] p1_wbe,
    output logic                p1_wdat_req,
    output logic                p1_rdat_vld,
    output logic [MCB_D_W-1:0]  p_rdat,
    output logic                mcb_bb,
    output logic                mcb_wr_n,
    output logic [1:0]          mcb_bl,
    output logic [MCB_B_W-1:0]  mcb_ba,
    output logic [MCB_R_W-1:0]  mcb_ra,
    output logic [MCB_C_W-1:0]  mcb_ca,
    input  logic                mcb_busy,
    input  logic                mcb_i_ready,
    input  logic                mcb_wdat_req,
    input  logic                mcb_rdat_vld,
    input  logic [MCB_D_W-1:0]  mcb_rdat,
    output logic [MCB_D_W-1:0]  mcb_wdat,
    output logic [MCB_BE_W-1:0] mcb_wbe,
    output logic                arb_err
);
    typedef enum logic {IDLE, GAP} state_t;
    state_t     state, state_nx;
    logic       rr, win, win_wr_n, win_full, issue, w_full, r_full, w_err, r_err;
    logic [1:0] win_bl, w_own, r_own;
    always_comb begin
        win      = (p0_req & p1_req) ? rr : p1_req;
        win_wr_n = win ? p1_wr_n : p0_wr_n;
        win_bl   = win ? p1_bl : p0_bl;
        win_full = win_wr_n ? r_full : w_full;
        issue    = (state == IDLE) & mcb_i_ready & ~mcb_busy & (p0_req | p1_req) & ~win_full;
        state_nx = (state == IDLE && issue) ? GAP : IDLE;
    end
    always_ff @(posedge mcb_clk or posedge mcb_rst) begin
        if (mcb_rst) state <= IDLE;
        else         state <= state_nx;
    end
    // rr holds the port favoured on the next contended grant
    always_ff @(posedge mcb_clk or posedge mcb_rst) begin
        if (mcb_rst) begin
            mcb_bb   <= 1'b0;
            mcb_wr_n <= 1'b1;
            mcb_bl   <= '0;
            mcb_ba   <= '0;
            mcb_ra   <= '0;
            mcb_ca   <= '0;
            p0_ack   <= 1'b0;
            p1_ack   <= 1'b0;
            rr       <= 1'b0;
            arb_err  <= 1'b0;
        end else begin
            mcb_bb  <= issue;
            p0_ack  <= issue & ~win;
            p1_ack  <= issue & win;
            arb_err <= arb_err | w_err | r_err | (issue & win_bl[1]);
            if (issue) begin
                mcb_wr_n <= win_wr_n;
                mcb_bl   <= {1'b0, win_bl != 2'b00};
                mcb_ba   <= win ? p1_ba : p0_ba;
                mcb_ra   <= win ? p1_ra : p0_ra;
                mcb_ca   <= win ? p1_ca : p0_ca;
                rr       <= ~win;
            end
        end
    end
    mcb_arb2_own #(.DEPTH(TAG_DEPTH)) u_wown (
        .clk(mcb_clk), .rst(mcb_rst), .push(issue & ~win_wr_n), .port(win),
        .bl8(win_bl != 2'b00), .beat(mcb_wdat_req), .full(w_full), .err(w_err), .own(w_own)
    );
    mcb_arb2_own #(.DEPTH(TAG_DEPTH)) u_rown (
        .clk(mcb_clk), .rst(mcb_rst), .push(issue & win_wr_n), .port(win),
        .bl8(win_bl != 2'b00), .beat(mcb_rdat_vld), .full(r_full), .err(r_err), .own(r_own)
    );
    always_comb begin
        p0_wdat_req = mcb_wdat_req & w_own[0];
        p1_wdat_req = mcb_wdat_req & w_own[1];
        p0_rdat_vld = mcb_rdat_vld & r_own[0];
        p1_rdat_vld = mcb_rdat_vld & r_own[1];
        p_rdat      = mcb_rdat;
        mcb_wdat    = w_own[1] ? p1_wdat : (w_own[0] ? p0_wdat : '0);
        mcb_wbe     = w_own[1] ? p1_wbe : (w_own[0] ? p0_wbe : '0);
    end
endmodule

// File: tb/tb_mcb_arb2.sv
// tb_mcb_arb2: directed scenarios plus a randomized run against a queue-based reference model.
module tb_mcb_arb2;
    localparam int BW = 2, RW = 13, CW = 9, DW = 32, BEW = 4, DEPTH = 4;
    logic mcb_clk = 1'b0, mcb_rst;
    logic p0_req, p0_wr_n, p0_ack, p0_wdat_req, p0_rdat_vld;
    logic p1_req, p1_wr_n, p1_ack, p1_wdat_req, p1_rdat_vld;
    logic [1:0] p0_bl, p1_bl, mcb_bl;
    logic [BW-1:0] p0_ba, p1_ba, mcb_ba;
    logic [RW-1:0] p0_ra, p1_ra, mcb_ra;
    logic [CW-1:0] p0_ca, p1_ca, mcb_ca;
    logic [DW-1:0] p0_wdat, p1_wdat, p_rdat, mcb_rdat, mcb_wdat;
    logic [BEW-1:0] p0_wbe, p1_wbe, mcb_wbe;
    logic mcb_bb, mcb_wr_n, mcb_busy, mcb_i_ready, mcb_wdat_req, mcb_rdat_vld, arb_err;
    int checks = 0, errors = 0;

    // reference model: per-direction owner queues with burst lengths
    int wq_p[$], wq_l[$], rq_p[$], rq_l[$];
    int wdone, rdone, fav;
    bit m_err, m_bb, m_ack0, m_ack1;
    logic m_wr_n;
    logic [1:0] m_bl;
    logic [BW-1:0] m_ba;
    logic [RW-1:0] m_ra;
    logic [CW-1:0] m_ca;

    mcb_arb2 dut (
        .mcb_clk(mcb_clk), .mcb_rst(mcb_rst),
        .p0_req(p0_req), .p0_wr_n(p0_wr_n), .p0_bl(p0_bl), .p0_ba(p0_ba), .p0_ra(p0_ra), .p0_ca(p0_ca),
        .p0_ack(p0_ack), .p0_wdat(p0_wdat), .p0_wbe(p0_wbe), .p0_wdat_req(p0_wdat_req), .p0_rdat_vld(p0_rdat_vld),
        .p1_req(p1_req), .p1_wr_n(p1_wr_n), .p1_bl(p1_bl), .p1_ba(p1_ba), .p1_ra(p1_ra), .p1_ca(p1_ca),
        .p1_ack(p1_ack), .p1_wdat(p1_wdat), .p1_wbe(p1_wbe), .p1_wdat_req(p1_wdat_req), .p1_rdat_vld(p1_rdat_vld),
        .p_rdat(p_rdat), .mcb_bb(mcb_bb), .mcb_wr_n(mcb_wr_n), .mcb_bl(mcb_bl), .mcb_ba(mcb_ba),
        .mcb_ra(mcb_ra), .mcb_ca(mcb_ca), .mcb_busy(mcb_busy), .mcb_i_ready(mcb_i_ready),
        .mcb_wdat_req(mcb_wdat_req), .mcb_rdat_vld(mcb_rdat_vld), .mcb_rdat(mcb_rdat),
        .mcb_wdat(mcb_wdat), .mcb_wbe(mcb_wbe), .arb_err(arb_err)
    );

    always #5 mcb_clk = ~mcb_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic model_reset();
        wq_p.delete(); wq_l.delete(); rq_p.delete(); rq_l.delete();
        wdone = 0; rdone = 0; fav = 0;
        m_err = 0; m_bb = 0; m_ack0 = 0; m_ack1 = 0;
        m_wr_n = 1'b1; m_bl = '0; m_ba = '0; m_ra = '0; m_ca = '0;
    endtask

    // advance the model across one rising edge using the inputs currently driven
    task automatic model_step();
        int win;
        logic wr;
        logic [1:0] bl;
        bit go;
        go = 0; win = 0; wr = 1'b1; bl = 2'b00;
        if (!m_bb && mcb_i_ready && !mcb_busy && (p0_req || p1_req)) begin
            win = (p0_req && p1_req) ? fav : (p1_req ? 1 : 0);
            wr  = (win == 1) ? p1_wr_n : p0_wr_n;
            bl  = (win == 1) ? p1_bl : p0_bl;
            go  = (wr ? rq_p.size() : wq_p.size()) < DEPTH;
        end
        if (mcb_wdat_req) begin
            if (wq_p.size() == 0) m_err = 1;
            else begin
                wdone++;
                if (wdone == wq_l[0]) begin void'(wq_p.pop_front()); void'(wq_l.pop_front()); wdone = 0; end
            end
        end
        if (mcb_rdat_vld) begin
            if (rq_p.size() == 0) m_err = 1;
            else begin
                rdone++;
                if (rdone == rq_l[0]) begin void'(rq_p.pop_front()); void'(rq_l.pop_front()); rdone = 0; end
            end
        end
        m_bb = go; m_ack0 = go && win == 0; m_ack1 = go && win == 1;
        if (go) begin
            if (bl[1]) m_err = 1;
            if (wr) begin rq_p.push_back(win); rq_l.push_back(bl == 2'b00 ? 4 : 8); end
            else begin wq_p.push_back(win); wq_l.push_back(bl == 2'b00 ? 4 : 8); end
            m_wr_n = wr; m_bl = (bl == 2'b00) ? 2'b00 : 2'b01;
            m_ba = (win == 1) ? p1_ba : p0_ba;
            m_ra = (win == 1) ? p1_ra : p0_ra;
            m_ca = (win == 1) ? p1_ca : p0_ca;
            fav = 1 - win;
        end
    endtask

    task automatic do_reset();
        mcb_rst = 1'b1;
        p0_req = 0; p0_wr_n = 1; p0_bl = 0; p0_ba = 0; p0_ra = 0; p0_ca = 0; p0_wdat = 0; p0_wbe = 0;
        p1_req = 0; p1_wr_n = 1; p1_bl = 0; p1_ba = 0; p1_ra = 0; p1_ca = 0; p1_wdat = 0; p1_wbe = 0;
        mcb_busy = 0; mcb_i_ready = 0; mcb_wdat_req = 0; mcb_rdat_vld = 0; mcb_rdat = 0;
        @(negedge mcb_clk); @(negedge mcb_clk);
        mcb_rst = 1'b0; mcb_i_ready = 1'b1;
        model_reset();
    endtask

    task automatic send(input int port, input logic wr_n, input logic [1:0] bl, output bit ok);
        if (port == 0) begin p0_req = 1; p0_wr_n = wr_n; p0_bl = bl; end
        else begin p1_req = 1; p1_wr_n = wr_n; p1_bl = bl; end
        ok = 0;
        for (int n = 0; n < 12 && !ok; n++) begin
            @(negedge mcb_clk); #1;
            ok = (port == 0) ? p0_ack : p1_ack;
        end
        if (port == 0) p0_req = 0; else p1_req = 0;
    endtask

    task automatic test_reset();
        do_reset(); #1;
        checks++; if (mcb_bb !== 1'b0) begin errors++; $display("FAIL reset_bb got=%b exp=0", mcb_bb); end
        checks++; if (mcb_wr_n !== 1'b1) begin errors++; $display("FAIL reset_wr_n got=%b exp=1", mcb_wr_n); end
        checks++; if ({p0_ack, p1_ack} !== 2'b00) begin errors++; $display("FAIL reset_ack got=%b exp=00", {p0_ack, p1_ack}); end
        checks++; if (arb_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", arb_err); end
        checks++; if ({mcb_bl, mcb_ba, mcb_ra, mcb_ca} !== '0) begin errors++; $display("FAIL reset_cmd got=%h exp=0", {mcb_bl, mcb_ba, mcb_ra, mcb_ca}); end
    endtask

    task automatic test_single_write();
        logic [DW-1:0] d;
        do_reset();
        p0_req = 1; p0_wr_n = 0; p0_bl = 2'b00; p0_ba = 1; p0_ra = 25; p0_ca = 96;
        @(negedge mcb_clk); #1;
        checks++; if (mcb_bb !== 1'b1) begin errors++; $display("FAIL sw_bb got=%b exp=1", mcb_bb); end
        checks++; if ({p0_ack, p1_ack} !== 2'b10) begin errors++; $display("FAIL sw_ack got=%b exp=10", {p0_ack, p1_ack}); end
        checks++; if ({mcb_wr_n, mcb_bl} !== 3'b000) begin errors++; $display("FAIL sw_type got=%b exp=000", {mcb_wr_n, mcb_bl}); end
        checks++; if (mcb_ba !== 2'd1 || mcb_ra !== 13'd25 || mcb_ca !== 9'd96) begin errors++; $display("FAIL sw_addr got=%0d/%0d/%0d exp=1/25/96", mcb_ba, mcb_ra, mcb_ca); end
        p0_req = 0;
        @(negedge mcb_clk); #1;
        checks++; if (mcb_bb !== 1'b0 || mcb_ca !== 9'd96) begin errors++; $display("FAIL sw_hold got=bb%b ca%0d exp=bb0 ca96", mcb_bb, mcb_ca); end
        for (int i = 0; i < 4; i++) begin
            d = $urandom; p0_wdat = d; p1_wdat = ~d; p0_wbe = BEW'(i + 1); p1_wbe = '0; mcb_wdat_req = 1;
            #1;
            checks++; if ({p0_wdat_req, p1_wdat_req} !== 2'b10) begin errors++; $display("FAIL sw_wreq%0d got=%b exp=10", i, {p0_wdat_req, p1_wdat_req}); end
            checks++; if (mcb_wdat !== d || mcb_wbe !== BEW'(i + 1)) begin errors++; $display("FAIL sw_wdat%0d got=%h/%h exp=%h/%h", i, mcb_wdat, mcb_wbe, d, BEW'(i + 1)); end
            @(negedge mcb_clk);
        end
        #1;
        checks++; if (arb_err !== 1'b0) begin errors++; $display("FAIL sw_noerr got=%b exp=0", arb_err); end
        #1;
        checks++; if (p0_wdat_req !== 1'b0 || mcb_wdat !== '0) begin errors++; $display("FAIL sw_empty got=%b/%h exp=0/0", p0_wdat_req, mcb_wdat); end
        @(negedge mcb_clk); mcb_wdat_req = 0; #1;
        checks++; if (arb_err !== 1'b1) begin errors++; $display("FAIL sw_orphan_err got=%b exp=1", arb_err); end
    endtask

    task automatic test_round_robin();
        int g = 0, last = -10, cyc = 0;
        bit prev_busy = 0, b;
        do_reset();
        p0_req = 1; p0_wr_n = 1; p0_bl = 2'b00; p0_ba = 0;
        p1_req = 1; p1_wr_n = 0; p1_bl = 2'b00; p1_ba = 3;
        while (g < 4 && cyc < 80) begin
            @(negedge mcb_clk); cyc++; #1;
            if (mcb_bb) begin
                checks++; if ({p0_ack, p1_ack} !== ((g % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_grant%0d got=%b", g, {p0_ack, p1_ack}); end
                checks++; if (cyc - last < 2) begin errors++; $display("FAIL rr_spacing got=%0d exp>=2", cyc - last); end
                checks++; if (prev_busy) begin errors++; $display("FAIL rr_busy got=issue exp=none while busy"); end
                checks++; if (mcb_ba !== ((g % 2 == 0) ? 2'd0 : 2'd3)) begin errors++; $display("FAIL rr_ba got=%0d", mcb_ba); end
                last = cyc; g++;
            end
            b = ($urandom % 2) == 1; mcb_busy = b; prev_busy = b;
        end
        checks++; if (g != 4) begin errors++; $display("FAIL rr_timeout got=%0d grants exp=4", g); end
        p0_req = 0; p1_req = 0; mcb_busy = 0;
    endtask

    task automatic test_read_order();
        bit ok;
        logic [DW-1:0] d;
        do_reset();
        send(1, 1'b1, 2'b01, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ro_ack1 got=none exp=ack"); end
        send(0, 1'b1, 2'b00, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ro_ack0 got=none exp=ack"); end
        for (int i = 0; i < 12; i++) begin
            d = $urandom; mcb_rdat = d; mcb_rdat_vld = 1; #1;
            checks++; if ({p0_rdat_vld, p1_rdat_vld} !== ((i < 8) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL ro_beat%0d got=%b", i, {p0_rdat_vld, p1_rdat_vld}); end
            checks++; if (p_rdat !== d) begin errors++; $display("FAIL ro_data%0d got=%h exp=%h", i, p_rdat, d); end
            @(negedge mcb_clk);
        end
        mcb_rdat_vld = 0; #1;
        checks++; if (arb_err !== 1'b0) begin errors++; $display("FAIL ro_err got=%b exp=0", arb_err); end
    endtask

    task automatic test_fifo_full();
        bit ok;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(0, 1'b0, 2'b00, ok);
            checks++; if (!ok) begin errors++; $display("FAIL ff_fill%0d got=none exp=ack", i); end
        end
        p0_req = 1; p0_wr_n = 0; p0_bl = 2'b00;
        for (int i = 0; i < 6; i++) begin
            @(negedge mcb_clk); #1;
            checks++; if (p0_ack !== 1'b0) begin errors++; $display("FAIL ff_blocked%0d got=%b exp=0", i, p0_ack); end
        end
        mcb_wdat_req = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge mcb_clk); #1;
            checks++; if (p0_ack !== 1'b0) begin errors++; $display("FAIL ff_prepop%0d got=%b exp=0", i, p0_ack); end
        end
        mcb_wdat_req = 0;
        @(negedge mcb_clk); #1;
        checks++; if (p0_ack !== 1'b1) begin errors++; $display("FAIL ff_release got=%b exp=1", p0_ack); end
        p0_req = 0;
    endtask

    task automatic test_orphan_beat();
        bit ok;
        do_reset();
        mcb_rdat_vld = 1; #1;
        checks++; if ({p0_rdat_vld, p1_rdat_vld} !== 2'b00) begin errors++; $display("FAIL ob_vld got=%b exp=00", {p0_rdat_vld, p1_rdat_vld}); end
        @(negedge mcb_clk); mcb_rdat_vld = 0; #1;
        checks++; if (arb_err !== 1'b1) begin errors++; $display("FAIL ob_err got=%b exp=1", arb_err); end
        send(1, 1'b1, 2'b00, ok);
        mcb_rdat_vld = 1;
        repeat (4) @(negedge mcb_clk);
        mcb_rdat_vld = 0; #1;
        checks++; if (arb_err !== 1'b1) begin errors++; $display("FAIL ob_sticky got=%b exp=1", arb_err); end
        do_reset(); #1;
        checks++; if (arb_err !== 1'b0) begin errors++; $display("FAIL ob_clear got=%b exp=0", arb_err); end
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        do_reset();
        send(0, 1'b0, 2'b01, ok);
        checks++; if (!ok || mcb_wr_n !== 1'b0) begin errors++; $display("FAIL rm_issue got=ack%b wr_n%b exp=ack1 wr_n0", ok, mcb_wr_n); end
        mcb_wdat_req = 1;
        @(negedge mcb_clk); @(negedge mcb_clk); #1;
        checks++; if (p0_wdat_req !== 1'b1) begin errors++; $display("FAIL rm_beat3 got=%b exp=1", p0_wdat_req); end
        mcb_rst = 1; #1;
        checks++; if (p0_wdat_req !== 1'b0 || mcb_wdat !== '0) begin errors++; $display("FAIL rm_steer got=%b/%h exp=0/0", p0_wdat_req, mcb_wdat); end
        checks++; if ({mcb_bb, mcb_wr_n, mcb_bl, p0_ack, arb_err} !== 6'b010000) begin errors++; $display("FAIL rm_regs got=%b exp=010000", {mcb_bb, mcb_wr_n, mcb_bl, p0_ack, arb_err}); end
        @(negedge mcb_clk); mcb_rst = 0; #1;
        checks++; if (p0_wdat_req !== 1'b0) begin errors++; $display("FAIL rm_after got=%b exp=0", p0_wdat_req); end
        @(negedge mcb_clk); mcb_wdat_req = 0; #1;
        checks++; if (arb_err !== 1'b1) begin errors++; $display("FAIL rm_err got=%b exp=1", arb_err); end
    endtask

    task automatic test_illegal_bl();
        bit ok;
        do_reset();
        send(1, 1'b1, 2'b11, ok);
        checks++; if (!ok || mcb_bl !== 2'b01) begin errors++; $display("FAIL ib_bl got=ack%b bl%b exp=ack1 bl01", ok, mcb_bl); end
        checks++; if (arb_err !== 1'b1) begin errors++; $display("FAIL ib_err got=%b exp=1", arb_err); end
        for (int i = 0; i < 9; i++) begin
            mcb_rdat_vld = 1; #1;
            checks++; if (p1_rdat_vld !== (i < 8)) begin errors++; $display("FAIL ib_beat%0d got=%b exp=%b", i, p1_rdat_vld, i < 8); end
            @(negedge mcb_clk);
        end
        mcb_rdat_vld = 0;
    endtask

    task automatic test_random();
        bit ew0, ew1, er0, er1;
        logic [DW-1:0] ewd;
        logic [BEW-1:0] ewb;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            @(negedge mcb_clk);
            if (m_ack0) p0_req = 0;
            else if (!p0_req && $urandom % 3 == 0) begin
                p0_req = 1; p0_wr_n = 1'($urandom); p0_bl = {1'b0, 1'($urandom)};
                p0_ba = BW'($urandom); p0_ra = RW'($urandom); p0_ca = CW'($urandom);
            end
            if (m_ack1) p1_req = 0;
            else if (!p1_req && $urandom % 3 == 0) begin
                p1_req = 1; p1_wr_n = 1'($urandom); p1_bl = {1'b0, 1'($urandom)};
                p1_ba = BW'($urandom); p1_ra = RW'($urandom); p1_ca = CW'($urandom);
            end
            mcb_busy = ($urandom % 3) == 0;
            mcb_i_ready = ($urandom % 8) != 0;
            mcb_wdat_req = wq_p.size() > 0 && ($urandom % 2) == 1;
            mcb_rdat_vld = rq_p.size() > 0 && ($urandom % 2) == 1;
            p0_wdat = $urandom; p1_wdat = $urandom; p0_wbe = BEW'($urandom); p1_wbe = BEW'($urandom);
            mcb_rdat = $urandom;
            #1;
            ew0 = mcb_wdat_req && wq_p.size() > 0 && wq_p[0] == 0;
            ew1 = mcb_wdat_req && wq_p.size() > 0 && wq_p[0] == 1;
            er0 = mcb_rdat_vld && rq_p.size() > 0 && rq_p[0] == 0;
            er1 = mcb_rdat_vld && rq_p.size() > 0 && rq_p[0] == 1;
            ewd = (wq_p.size() == 0) ? '0 : (wq_p[0] == 1 ? p1_wdat : p0_wdat);
            ewb = (wq_p.size() == 0) ? '0 : (wq_p[0] == 1 ? p1_wbe : p0_wbe);
            checks++; if ({mcb_bb, p0_ack, p1_ack} !== {m_bb, m_ack0, m_ack1}) begin errors++; $display("FAIL rnd_issue c=%0d got=%b exp=%b", c, {mcb_bb, p0_ack, p1_ack}, {m_bb, m_ack0, m_ack1}); end
            checks++; if ({mcb_wr_n, mcb_bl, mcb_ba, mcb_ra, mcb_ca} !== {m_wr_n, m_bl, m_ba, m_ra, m_ca}) begin errors++; $display("FAIL rnd_cmd c=%0d got=%h exp=%h", c, {mcb_wr_n, mcb_bl, mcb_ba, mcb_ra, mcb_ca}, {m_wr_n, m_bl, m_ba, m_ra, m_ca}); end
            checks++; if ({p0_wdat_req, p1_wdat_req, p0_rdat_vld, p1_rdat_vld} !== {ew0, ew1, er0, er1}) begin errors++; $display("FAIL rnd_steer c=%0d got=%b exp=%b", c, {p0_wdat_req, p1_wdat_req, p0_rdat_vld, p1_rdat_vld}, {ew0, ew1, er0, er1}); end
            checks++; if (mcb_wdat !== ewd || mcb_wbe !== ewb) begin errors++; $display("FAIL rnd_wdat c=%0d got=%h/%h exp=%h/%h", c, mcb_wdat, mcb_wbe, ewd, ewb); end
            checks++; if (p_rdat !== mcb_rdat) begin errors++; $display("FAIL rnd_rdat c=%0d got=%h exp=%h", c, p_rdat, mcb_rdat); end
            checks++; if (arb_err !== m_err) begin errors++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, arb_err, m_err); end
            model_step();
        end
        p0_req = 0; p1_req = 0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_read_order();
        test_fifo_full();
        test_orphan_beat();
        test_reset_mid_burst();
        test_illegal_bl();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
